// File: rtl/intra_xform_pkg.sv
// Shared definitions for the 4x4 forward residual transform.
// Contents: the FSM state type, the H.264 4x4 forward core transform matrix
// C, and default pixel/coefficient widths.
package intra_xform_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int COEF_W_DEF = 16;

  typedef enum logic {
    LOAD = 1'b0,
    OUT  = 1'b1
  } state_t;

  // Forward core transform matrix, C[row][col].
  localparam int C [4][4] = '{
    '{ 1,  1,  1,  1},
    '{ 2,  1, -1, -2},
    '{ 1, -1, -1,  1},
    '{ 1, -2,  2, -1}
  };

endpackage

// File: rtl/intra_residual_xform4x4_fwd_core4.sv
// fwd_core4: combinational 1-D forward core transform, y = C * x.
// Ports:
//   x_i : 4 signed lanes of IN_W bits, lane k at [k*IN_W +: IN_W]
//   y_o : 4 signed lanes of OUT_W bits, lane i at [i*OUT_W +: OUT_W]
// OUT_W must exceed IN_W by enough to hold a gain of 6 (3 bits).
module fwd_core4
  import intra_xform_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int OUT_W = 12
) (
  input  logic [4*IN_W-1:0]  x_i,
  output logic [4*OUT_W-1:0] y_o
);

  logic signed [IN_W-1:0]  xs;
  logic signed [OUT_W-1:0] xe;
  logic signed [OUT_W-1:0] cw;
  logic signed [OUT_W-1:0] acc;

  // The coefficients are small constants, so each product reduces to
  // shifts and adds; the sum is exact within OUT_W.
  always_comb begin
    y_o = '0;
    xs  = '0;
    xe  = '0;
    cw  = '0;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      acc = '0;
      for (int k = 0; k < 4; k++) begin
        xs  = signed'(x_i[k*IN_W +: IN_W]);
        xe  = OUT_W'(xs);
        cw  = OUT_W'(C[i][k]);
        acc = acc + cw * xe;
      end
      y_o[i*OUT_W +: OUT_W] = acc;
    end
  end

endmodule

// File: rtl/intra_residual_xform4x4.sv
// intra_residual_xform4x4: residual formation plus H.264 4x4 forward core
// transform. Accepts four rows of original/predicted pixels, row-transforms
// each residual row into a buffer, then emits four rows of column-transformed
// coefficients.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : input row handshake
//   in_orig, in_pred    : 4 unsigned PIX_W lanes, lane 0 = leftmost
//   out_valid/out_ready : output row handshake
//   out_coef            : 4 signed COEF_W lanes (zero when not valid)
//   out_row, out_last   : row index of out_coef, high with row 3
//   blk_count           : completed blocks, wraps mod 2^16
module intra_residual_xform4x4
  import intra_xform_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*PIX_W-1:0]  in_orig,
  input  logic [4*PIX_W-1:0]  in_pred,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*COEF_W-1:0] out_coef,
  output logic [1:0]          out_row,
  output logic                out_last,
  output logic [15:0]         blk_count
);

  localparam int RES_W = PIX_W + 1;
  localparam int T_W   = PIX_W + 4;

  state_t            state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic [15:0]       blk_q, blk_d;
  logic              wr_en;
  logic [4*T_W-1:0]  buf_q [4];

  logic [4*RES_W-1:0]  res_row;
  logic [4*T_W-1:0]    t_row;
  logic [4*T_W-1:0]    col_in  [4];
  logic [4*COEF_W-1:0] col_out [4];

  // Residual: zero-extend both pixels by one bit so the difference is an
  // exact (PIX_W+1)-bit two's complement value.
  always_comb begin
    res_row = '0;
    for (int j = 0; j < 4; j++) begin
      res_row[j*RES_W +: RES_W] = {1'b0, in_orig[j*PIX_W +: PIX_W]}
                                - {1'b0, in_pred[j*PIX_W +: PIX_W]};
    end
  end

  fwd_core4 #(.IN_W(RES_W), .OUT_W(T_W)) u_row_xform (
    .x_i (res_row),
    .y_o (t_row)
  );

  // Column j of the buffer feeds column transform j; lane k of its input is
  // buffer row k.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      col_in[j] = '0;
      for (int k = 0; k < 4; k++) begin
        col_in[j][k*T_W +: T_W] = buf_q[k][j*T_W +: T_W];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_col
    fwd_core4 #(.IN_W(T_W), .OUT_W(COEF_W)) u_col_xform (
      .x_i (col_in[g]),
      .y_o (col_out[g])
    );
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    blk_d   = blk_q;
    wr_en   = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          row_d = row_q + 2'd1;
          if (row_q == 2'd3) state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          row_d = row_q + 2'd1;
          if (row_q == 2'd3) begin
            state_d = LOAD;
            blk_d   = blk_q + 16'd1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      row_q   <= '0;
      blk_q   <= '0;
      for (int k = 0; k < 4; k++) buf_q[k] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      blk_q   <= blk_d;
      if (wr_en) buf_q[row_q] <= t_row;
    end
  end

  // Outputs are gated to zero outside the OUT state.
  always_comb begin
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == OUT);
    out_row   = out_valid ? row_q : 2'd0;
    out_last  = out_valid && (row_q == 2'd3);
    out_coef  = '0;
    if (out_valid) begin
      for (int j = 0; j < 4; j++) begin
        out_coef[j*COEF_W +: COEF_W] = col_out[j][row_q*COEF_W +: COEF_W];
      end
    end
    blk_count = blk_q;
  end

endmodule

// File: tb/tb_intra_residual_xform4x4.sv
module tb_intra_residual_xform4x4;

  localparam int PW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [4*PW-1:0] in_orig;
  logic [4*PW-1:0] in_pred;
  logic          out_valid;
  logic          out_ready;
  logic [4*CW-1:0] out_coef;
  logic [1:0]    out_row;
  logic          out_last;
  logic [15:0]   blk_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] ob [4][4];
  logic [7:0] pb [4][4];
  int         ex [4][4];

  intra_residual_xform4x4 #(.PIX_W(PW), .COEF_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_orig   (in_orig),
    .in_pred   (in_pred),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_row   (out_row),
    .out_last  (out_last),
    .blk_count (blk_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lane(input int j);
    logic signed [CW-1:0] v;
    v = out_coef[j*CW +: CW];
    return int'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fill every lane with o/p; expected block has only Y[0][0] = y00.
  task automatic set_const(input int o, input int p, input int y00);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) begin
        ob[r][j] = 8'(o);
        pb[r][j] = 8'(p);
        ex[r][j] = 0;
      end
    ex[0][0] = y00;
  endtask

  task automatic send_row(input int r);
    chk("in_ready_load", int'(in_ready), 1);
    in_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_orig[j*PW +: PW] = ob[r][j];
      in_pred[j*PW +: PW] = pb[r][j];
    end
    tick();
    in_valid = 1'b0;
    in_orig  = '0;
    in_pred  = '0;
  endtask

  task automatic send_block(input bit gaps);
    for (int r = 0; r < 4; r++) begin
      send_row(r);
      if (gaps && r < 3) tick();
    end
    chk("latency_out_valid", int'(out_valid), 1);
    chk("latency_in_ready", int'(in_ready), 0);
  endtask

  // Receive four rows; optionally stall 3 cycles on row stall_row.
  task automatic recv_block(input string name, input int stall_row, input int exp_blk);
    int budget;
    for (int r = 0; r < 4; r++) begin
      budget = 0;
      while (!out_valid && budget < 16) begin
        tick();
        budget++;
      end
      if (!out_valid) begin
        chk({name, "_timeout"}, 0, 1);
        return;
      end
      if (r == stall_row) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk({name, "_stall_row"}, int'(out_row), r);
          chk({name, "_stall_coef1"}, lane(1), ex[r][1]);
          chk({name, "_stall_in_ready"}, int'(in_ready), 0);
          chk({name, "_stall_valid"}, int'(out_valid), 1);
        end
        out_ready = 1'b1;
      end
      chk({name, "_row"}, int'(out_row), r);
      chk({name, "_last"}, int'(out_last), (r == 3) ? 1 : 0);
      for (int j = 0; j < 4; j++) chk({name, "_coef"}, lane(j), ex[r][j]);
      tick();
    end
    chk({name, "_back_in_ready"}, int'(in_ready), 1);
    chk({name, "_out_valid_low"}, int'(out_valid), 0);
    chk({name, "_blk_count"}, int'(blk_count), exp_blk);
  endtask

  task automatic check_idle(input string name);
    chk({name, "_in_ready"}, int'(in_ready), 1);
    chk({name, "_out_valid"}, int'(out_valid), 0);
    chk({name, "_out_coef"}, int'(out_coef != '0), 0);
    chk({name, "_out_row"}, int'(out_row), 0);
    chk({name, "_out_last"}, int'(out_last), 0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_orig   = '0;
    in_pred   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check_idle("in_reset");
    chk("in_reset_blk", int'(blk_count), 0);
    reset = 1'b0;
    tick();
    check_idle("post_reset");
    chk("post_reset_blk", int'(blk_count), 0);

    // Zero residual.
    set_const(8'h37, 8'h37, 0);
    send_block(1'b0);
    recv_block("zero", -1, 1);

    // Constant residual of 10: 4*4*10.
    set_const(110, 100, 160);
    send_block(1'b0);
    recv_block("const", -1, 2);

    // Extremes: +/-4*4*255.
    set_const(255, 0, 4080);
    send_block(1'b0);
    recv_block("max_pos", -1, 3);
    set_const(0, 255, -4080);
    send_block(1'b0);
    recv_block("max_neg", -1, 4);

    // Impulse at row 0, lane 0, with gaps between input rows.
    set_const(0, 0, 1);
    ob[0][0] = 8'd1;
    ex[0] = '{1, 2, 1, 1};
    ex[1] = '{2, 4, 2, 2};
    ex[2] = '{1, 2, 1, 1};
    ex[3] = '{1, 2, 1, 1};
    send_block(1'b1);
    recv_block("impulse", -1, 5);

    // Same impulse block, stalled on output row 1.
    send_block(1'b0);
    recv_block("bp", 1, 6);

    // Reset after two accepted rows of nonzero residual.
    set_const(255, 0, 4080);
    send_row(0);
    send_row(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("mid_reset");
    chk("mid_reset_blk", int'(blk_count), 0);
    set_const(110, 100, 160);
    send_block(1'b0);
    recv_block("after_reset", -1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/intra_residual_xform4x4.md
# intra_residual_xform4x4

Forward residual and integer-transform stage that sits directly downstream of `encoder_intra`. It accepts one 4x4 luma block as four rows of original and intra-predicted pixels. It forms the signed residual, applies the H.264 4x4 forward core transform Y = C·X·Cᵀ, and emits four rows of unscaled coefficients to the quantiser. Both input and output use valid/ready handshakes, and the block buffers exactly one block.

## Interface
- `PIX_W`, default 8: pixel width, unsigned.
- `COEF_W`, default 16: coefficient width, signed two's complement. It must satisfy COEF_W ≥ PIX_W+8.
- `clk`, in, 1: the single clock. Everything is rising-edge.
- `reset`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: the input row is valid.
- `in_ready`, out, 1: the block can accept a row.
- `in_orig`, in, 4*PIX_W: original pixel row. Lane j sits at bits [j*PIX_W +: PIX_W], and j=0 is the leftmost column.
- `in_pred`, in, 4*PIX_W: predicted pixel row, same lane layout.
- `out_valid`, out, 1: the coefficient row is valid.
- `out_ready`, in, 1: the consumer accepts the row.
- `out_coef`, out, 4*COEF_W: coefficient row, same lane layout.
- `out_row`, out, 2: row index 0..3 of `out_coef`.
- `out_last`, out, 1: high with row 3.
- `blk_count`, out, 16: number of completed blocks. It wraps modulo 2^16.

## Operation
- The FSM has two states: LOAD and OUT.
- **LOAD:**
  - `in_ready`=1 and `out_valid`=0.
  - On each accepted row k (k = 0..3, held in a 2-bit row counter):
    - residual x_j = orig_j − pred_j, a signed (PIX_W+1)-bit value;
    - row transform t = C·x, where C rows are [1,1,1,1], [2,1,−1,−2], [1,−1,−1,1], [1,−2,2,−1];
    - store t as (PIX_W+4)-bit signed values in buffer row k.
  - After row 3 is accepted, move to OUT and clear the row counter.
- **OUT:**
  - `in_ready`=0 and `out_valid`=1.
  - `out_coef` lane j = Σ_k C[out_row][k]·T[k][j], computed combinationally from the buffer and sign-extended to COEF_W.
  - `out_row` advances only on handshake (`out_valid`&&`out_ready`).
  - After row 3 is accepted, return to LOAD and increment `blk_count`.
- **Width rules:**
  - The row stage gain is ≤ 6 and the column stage gain is ≤ 6, so |Y| ≤ 36·(2^PIX_W−1).
  - No saturation is needed or permitted.
- **Qualifiers and gating:**
  - `in_orig` and `in_pred` are ignored unless a row is accepted.
  - `out_coef`, `out_row` and `out_last` are forced to 0 when `out_valid`=0.
- **Backpressure:**
  - While `out_valid`&&!`out_ready`, all outputs are held stable.
  - The FSM does not move.
- **Reset:**
  - State returns to LOAD, and the row counter and buffer are cleared.
  - `blk_count` returns to 0.
  - Output values during and immediately after reset: `in_ready`=1, `out_valid`=0, `out_coef`=0, `out_row`=0, `out_last`=0, `blk_count`=0.
  - Reset in the middle of a block discards the partial block. No partial output is produced.

## Timing
- First output row: `out_valid` rises on the cycle after the edge that accepts input row 3 (1-cycle latency).
- Subsequent output rows follow one per cycle while `out_ready`=1.
- Return to LOAD: `in_ready` rises on the cycle after output row 3 is accepted. `blk_count` updates on that same edge.
- Input and output never overlap. Minimum throughput is 8 cycles per block with no stalls.
- `in_valid` may be held or dropped between rows. Gaps only stretch the LOAD phase.

## Structure
- **Package `intra_xform_pkg`:**
  - state enum {LOAD, OUT};
  - the transform coefficient matrix C as localparam constants;
  - default widths PIX_W and COEF_W.
- **Sub-module `fwd_core4`:**
  - combinational 1-D butterfly, parameterised input and output width, y = C·x;
  - one instance forms the row transform at the input;
  - four instances, one per column, form the column transforms;
  - `out_row` selects the output row from the column-transform results.
- The top level contains the FSM, row counter, 4x4 buffer, handshake logic and `blk_count`.

## Test plan
- **Zero residual.** Apply four rows with orig=pred=0x37. Required: all 16 coefficients are 0, `out_last` is high only with row 3, and `blk_count`=1.
- **Constant residual.** Apply orig=110 and pred=100 in every lane. Required: Y[0][0]=160 and the other 15 coefficients are 0.
- **Extremes.**
  - orig=255, pred=0 in every lane: required Y[0][0]=4080, all others 0.
  - orig=0, pred=255 in every lane: required Y[0][0]=−4080, all others 0.
- **Impulse.** Residual 1 at row 0, lane 0 (orig=1, pred=0); all other pixels have zero residual. Required output rows:
  - row 0: [1,2,1,1];
  - row 1: [2,4,2,2];
  - row 2: [1,2,1,1];
  - row 3: [1,2,1,1].
- **Backpressure.** Hold `out_ready`=0 for 3 cycles while `out_row`=1. Required: `out_coef` and `out_row` stay stable, `in_ready` stays 0, and the following rows are correct.
- **Reset mid-LOAD.** Accept 2 rows of nonzero residual, assert `reset` for 1 cycle, then send the constant-residual block. Required: output equals the constant-residual block exactly, and `blk_count`=1.
